// File: rtl/shift_arb.sv
// Round-robin two-port arbiter sequencing requests onto one shared 32-bit barrel shifter.
// Includes the shift32 shifter it drives; result/done/err are registered one cycle after the grant.

module shift32 (
   input  logic [31:0] in,
   input  logic [4:0]  shamt,
   input  logic        sll,
   input  logic        srl,
   input  logic        sra,
   output logic [31:0] out
);
   always_comb begin
      out = '0;
      if (sll)      out = in << shamt;
      else if (srl) out = in >> shamt;
      else if (sra) out = $signed(in) >>> shamt;
   end
endmodule

module shift_arb #(
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic        m_clock,
   input  logic        p_reset,
   input  logic        a_req,
   input  logic [1:0]  a_op,
   input  logic [31:0] a_in,
   input  logic [4:0]  a_shamt,
   input  logic        b_req,
   input  logic [1:0]  b_op,
   input  logic [31:0] b_in,
   input  logic [4:0]  b_shamt,
   output logic        a_done,
   output logic        b_done,
   output logic [31:0] result,
   output logic        err
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_A = 2'd1, BUSY_B = 2'd2} state_t;

   // Handshake: a request is held until its done pulse; a port whose done is high is not
   // eligible that cycle, so the same request is never granted twice.
   state_t      state;
   logic        last;        // 0 = A granted most recently, 1 = B
   logic        a_elig, b_elig;
   logic [1:0]  sel_op;
   logic [31:0] sel_in;
   logic [4:0]  sel_shamt;
   logic        sh_sll, sh_srl, sh_sra;
   logic [31:0] sh_out;

   assign a_elig = a_req & ~a_done;
   assign b_elig = b_req & ~b_done;

   always_comb begin
      state     = IDLE;
      sel_op    = 2'b00;
      sel_in    = '0;
      sel_shamt = '0;
      if (a_elig && b_elig) state = last ? BUSY_A : BUSY_B;
      else if (a_elig)      state = BUSY_A;
      else if (b_elig)      state = BUSY_B;
      case (state)
         BUSY_A: begin
            sel_op    = a_op;
            sel_in    = a_in;
            sel_shamt = a_shamt;
         end
         BUSY_B: begin
            sel_op    = b_op;
            sel_in    = b_in;
            sel_shamt = b_shamt;
         end
         default: ;
      endcase
   end

   // An illegal op (00) or no grant leaves all controls low, so the shifter outputs 0.
   assign sh_sll = (sel_op == 2'b01);
   assign sh_srl = (sel_op == 2'b10);
   assign sh_sra = (sel_op == 2'b11);

   shift32 u_shift (
      .in    (sel_in),
      .shamt (sel_shamt),
      .sll   (sh_sll),
      .srl   (sh_srl),
      .sra   (sh_sra),
      .out   (sh_out)
   );

   always_ff @(posedge m_clock) begin
      if (p_reset) begin
         result <= '0;
         a_done <= 1'b0;
         b_done <= 1'b0;
         err    <= 1'b0;
         last   <= ~PRIO_INIT;
      end else begin
         a_done <= (state == BUSY_A);
         b_done <= (state == BUSY_B);
         err    <= (state != IDLE) && (sel_op == 2'b00);
         if (state != IDLE) begin
            result <= sh_out;
            last   <= (state == BUSY_B);
         end
      end
   end
endmodule

// File: doc/shift_arb.md
# shift_arb

Two-port arbiter and sequencer for the shared 32-bit barrel shifter (`shift32`) in the p32 execution unit. It accepts shift requests from two requesters: port A, the integer ALU issue slot, and port B, the load/store alignment path. It grants one request per cycle using round-robin priority and drives the shifter's one-hot `sll`/`srl`/`sra` controls for the winner. The shifter output is captured into a result register, and the owning requester receives a one-cycle `done` pulse.

## Interface

Parameters:
- `PRIO_INIT`, default 0. Port preferred on the first conflict after reset: 0 = A, 1 = B.

Ports:
- `m_clock`  in  1  clock; all state updates on the rising edge.
- `p_reset`  in  1  reset; synchronous, active-high.
- `a_req`  in  1  port A request; held high until `a_done`.
- `a_op`  in  2  port A operation: 01 = sll, 10 = srl, 11 = sra, 00 = illegal.
- `a_in`  in  32  port A operand.
- `a_shamt`  in  5  port A shift amount.
- `b_req`, `b_op`, `b_in`, `b_shamt`  in  1/2/32/5  port B equivalents.
- `a_done`  out  1  one-cycle pulse: `result` belongs to A.
- `b_done`  out  1  one-cycle pulse: `result` belongs to B.
- `result`  out  32  registered shifter output.
- `err`  out  1  one-cycle pulse alongside `done`: the completed op was illegal.

## Operation

**Shifter instance**
- Instantiates one `shift32`.
- Its `in`/`shamt` are muxed from the granted port.
- At most one of `sll`/`srl`/`sra` is asserted in any cycle. All three are 0 when nothing is granted or the op is illegal.

**Eligibility**
- A port is eligible in cycle N when its `req` = 1 and its `done` = 0 in cycle N.
- A requester sees `done` and drops or renews `req` in the following cycle. Eligibility therefore blocks a double grant of the same request.

**Grant**
- Only one port eligible: that port wins.
- Both eligible: the port not granted most recently wins.
- State: a 1-bit `last` register holding the last granted port. It updates only on a grant.
- Reset value of `last` = NOT `PRIO_INIT`, so the port selected by `PRIO_INIT` wins the first conflict.

**Capture**
- On the edge ending a grant cycle N:
  - `result` <= shifter output.
  - The winner's `done` <= 1.
  - `err` <= (op == 00).
- Illegal op: no shifter control is asserted and `result` <= 0. It still completes and pulses `done`.
- No grant in cycle N: `a_done` = `b_done` = `err` = 0 in N+1, and `result` holds its previous value.

**Operand sampling**
- Operands are sampled only in the grant cycle.
- Changes to `a_in`, `a_shamt` or `a_op` while `req` is high but not yet granted are taken as the new request contents. The same applies to port B.

**Internal states**
- IDLE: no grant this cycle.
- BUSY_A: A granted this cycle.
- BUSY_B: B granted this cycle.
- The state is derived combinationally from eligibility and `last`. Registered state consists of `last`, `result`, `a_done`, `b_done` and `err` only.

## Timing

**Latency**
- Exactly 1 cycle: grant in N, `done` and `result` valid in N+1.

**Throughput**
- One completion per cycle when both ports are active; grants alternate A, B, A, B.
- A single port alone completes every other cycle, because of the eligibility rule.

**Reset values**
- `result` = 0, `a_done` = 0, `b_done` = 0, `err` = 0, `last` = NOT `PRIO_INIT`.

**Reset mid-operation**
- `p_reset` high during the capture edge of a grant in N: the grant is discarded.
- In N+1, `done` = 0, `err` = 0 and `result` = 0.
- Requests still held after reset deasserts are re-arbitrated from reset priority.

**Simultaneous events**
- Conflict in the same cycle that the other port's `done` is high: the `done` port is ineligible, and the other port wins regardless of `last`.
- `a_done` and `b_done` are never high together.

**Arithmetic**
- Identical to `shift32`: logical shifts fill with 0, `sra` fills with `in[31]`.
- `shamt` 0 passes the operand through. Only 5 bits of `shamt` are used.

## Test plan

- **Reset:** hold `p_reset` 2 cycles with `a_req` = `b_req` = 1 -> `result` = 0, all `done`/`err` = 0 throughout reset. With `PRIO_INIT` = 0, the first cycle after reset grants A.
- **Single port:** A only, sll, `a_in` = 0x00000001, `a_shamt` = 31 in cycle N -> `a_done` = 1 and `result` = 0x80000000 in N+1. With `a_req` held, the next `a_done` arrives at N+3.
- **Conflict:** cycle N, A srl 0x80000000 by 4 and B sra 0x80000000 by 4 -> N+1: `a_done`, `result` = 0x08000000; N+2: `b_done`, `result` = 0xF8000000.
- **Fairness:** both ports hold `req` continuously for 20 cycles with varying ops -> strict A/B alternation, 20 completions, no starvation, never both `done` high.
- **Illegal op:** B `op` = 00, `b_in` = 0xFFFFFFFF -> next cycle `b_done` = 1, `err` = 1, `result` = 0, no shifter control asserted in the grant cycle.
- **Reset mid-operation:** A granted in N (sll 0x1 by 1) with `p_reset` = 1 at the N edge -> N+1: `a_done` = 0, `result` = 0. After reset the request is re-served and yields `result` = 0x00000002.
